// File: rtl/vc_circular_buffer_pkg.sv
// Shared types and sizing for the virtual-channel circular buffer.
package vc_circular_buffer_pkg;

   localparam int unsigned NUM_VC_DEF = 2;
   localparam int unsigned VC_W       = (NUM_VC_DEF > 1) ? $clog2(NUM_VC_DEF) : 1;
   localparam int unsigned PAYLOAD_W  = 16;

   typedef struct packed {
      logic [VC_W-1:0]      vc_id;
      logic [PAYLOAD_W-1:0] payload;
   } flit_Data;

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual channel: circular FIFO with occupancy counter and on/off hysteresis.
// Optional sticky error flag when VCBUF_ERR_CHECK_EN is defined.
module vc_fifo_slice
   import vc_circular_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned OFF_THRESH = DEPTH - 2,
   parameter int unsigned ON_THRESH  = DEPTH - 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     wr_i,
   input  logic     rd_i,
   input  flit_Data wr_data_i,
   output flit_Data head_c,
   output logic     empty_o,
   output logic     full_o,
   output logic     on_off_o
`ifdef VCBUF_ERR_CHECK_EN
   ,
   output logic     err_o
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   flit_Data         mem_q [DEPTH];
   flit_Data         mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             on_off_q, on_off_d;
   logic             wr_ok, rd_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A full VC still accepts a write when it is popped in the same cycle.
   always_comb begin
      rd_ok    = rd_i && !empty_q;
      wr_ok    = wr_i && (!full_q || rd_i);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      empty_d  = (count_d == '0);
      full_d   = (count_d == CNT_W'(DEPTH));
      on_off_d = on_off_q;
      if (count_d >= CNT_W'(OFF_THRESH))     on_off_d = 1'b0;
      else if (count_d <= CNT_W'(ON_THRESH)) on_off_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         on_off_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         on_off_q <= on_off_d;
      end
   end

   // Storage is not reset; empty_q masks stale contents on the output.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_c   = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty_o  = empty_q;
   assign full_o   = full_q;
   assign on_off_o = on_off_q;

`ifdef VCBUF_ERR_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (wr_i && full_q && !rd_i) | (rd_i && empty_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err_o = err_q;
`endif

endmodule

// File: rtl/vc_circular_buffer.sv
// Multi-VC input buffer: one vc_fifo_slice per virtual channel, show-ahead read mux.
// Define VCBUF_ERR_CHECK_EN to add sticky per-VC err_o flags.
module vc_circular_buffer
   import vc_circular_buffer_pkg::*;
#(
   parameter int unsigned BUFFER_SIZE = 8,
   parameter int unsigned NUM_VC      = NUM_VC_DEF,
   parameter int unsigned OFF_THRESH  = BUFFER_SIZE - 2,
   parameter int unsigned ON_THRESH   = BUFFER_SIZE - 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  flit_Data          input_Data,
   input  logic              write_i,
   input  logic              read_i,
   input  logic [VC_W-1:0]   read_vc_i,
   output flit_Data          output_Data,
   output logic [NUM_VC-1:0] buf_empty,
   output logic [NUM_VC-1:0] buf_full,
   output logic [NUM_VC-1:0] buf_On_Off
`ifdef VCBUF_ERR_CHECK_EN
   ,
   output logic [NUM_VC-1:0] err_o
`endif
);

   flit_Data head_c [NUM_VC];

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic wr_c, rd_c;

      assign wr_c = write_i && (input_Data.vc_id == VC_W'(v));
      assign rd_c = read_i && (read_vc_i == VC_W'(v));

      vc_fifo_slice #(
         .DEPTH      (BUFFER_SIZE),
         .OFF_THRESH (OFF_THRESH),
         .ON_THRESH  (ON_THRESH)
      ) u_slice (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_i      (wr_c),
         .rd_i      (rd_c),
         .wr_data_i (input_Data),
         .head_c    (head_c[v]),
         .empty_o   (buf_empty[v]),
         .full_o    (buf_full[v]),
         .on_off_o  (buf_On_Off[v])
`ifdef VCBUF_ERR_CHECK_EN
         ,
         .err_o     (err_o[v])
`endif
      );
   end

   // Out-of-range read_vc_i presents all zeros.
   always_comb begin
      output_Data = '0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
         if (read_vc_i == VC_W'(v)) output_Data = head_c[v];
      end
   end

endmodule

// File: doc/vc_circular_buffer.md
VC_CIRCULAR_BUFFER -- requirements
Module: vc_circular_buffer

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 8, flits per VC (>=2, power of two not required).
REQ-002 SHALL have parameter NUM_VC, default 2, number of virtual channels (>=1).
REQ-003 SHALL have parameter OFF_THRESH, default BUFFER_SIZE-2, occupancy at which a VC turns off.
REQ-004 SHALL have parameter ON_THRESH, default BUFFER_SIZE-4, occupancy at or below which a VC turns back on (ON_THRESH < OFF_THRESH).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 input_Data  input  flit_Data  incoming flit; its vc_id field selects the destination VC.
REQ-008 write_i  input  1  write request for input_Data.
REQ-009 read_i  input  1  read (pop) request.
REQ-010 read_vc_i  input  VC_W  VC to read and to present on output_Data.
REQ-011 output_Data  output  flit_Data  head flit of VC read_vc_i.
REQ-012 buf_empty  output  NUM_VC  per-VC empty flag.
REQ-013 buf_full  output  NUM_VC  per-VC full flag.
REQ-014 buf_On_Off  output  NUM_VC  per-VC on/off credit signal; 1 = upstream may send.

Function
REQ-015 Each VC SHALL be an independent circular FIFO with read/write pointers wrapping from BUFFER_SIZE-1 to 0, plus an occupancy counter of width $clog2(BUFFER_SIZE+1).
REQ-016 output_Data SHALL be combinational show-ahead of the head of VC read_vc_i; all-zero when that VC is empty.
REQ-017 A write SHALL become visible on output_Data the cycle after it is accepted (1-cycle latency, no same-cycle bypass).
REQ-018 A write SHALL be accepted when the target VC is not full, or when it is full and the same VC is read in the same cycle.
REQ-019 A write to a full VC without a same-VC read SHALL be dropped with no state change.
REQ-020 A read of an empty VC SHALL be ignored, including when the same VC is written that cycle (the write is still accepted).
REQ-021 A simultaneous read and write on the same non-empty VC SHALL advance both pointers and leave the count unchanged.
REQ-022 Reads and writes on different VCs SHALL proceed independently in the same cycle.
REQ-023 buf_empty/buf_full SHALL derive from the registered count (count==0 / count==BUFFER_SIZE).
REQ-024 buf_On_Off[v] SHALL be a register: cleared when next count >= OFF_THRESH, set when next count <= ON_THRESH, held otherwise (hysteresis).

Reset
REQ-025 On rst_n low, all pointers and counts SHALL clear, buf_empty SHALL be all ones, buf_full all zeros, and buf_On_Off all ones, regardless of traffic in flight.
REQ-026 Storage contents need not reset; output_Data SHALL read all-zero after reset because every VC is empty.

Configuration
REQ-027 With VCBUF_ERR_CHECK_EN defined, the block SHALL add output err_o [NUM_VC] of sticky per-VC error flags, set on a dropped write (REQ-019) or an ignored read (REQ-020) and cleared only by reset.
REQ-028 Without VCBUF_ERR_CHECK_EN, err_o and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-029 Package params SHALL hold flit_Data (with vc_id field), NUM_VC default and VC_W = $clog2(NUM_VC) (min 1).
REQ-030 Per-VC FIFO plus counter SHALL be sub-module vc_fifo_slice, instantiated NUM_VC times via generate.

Verification
REQ-031 Reset then no traffic -> buf_empty=all 1, buf_full=0, buf_On_Off=all 1, output_Data=0.
REQ-032 8 writes to VC0 (BUFFER_SIZE=8) -> buf_On_Off[0]=0 after the 6th, buf_full[0]=1 after the 8th, 9th write dropped; 8 reads return flits in order.
REQ-033 Fill VC0 to 8, read down to 4 -> buf_On_Off[0] stays 0 at counts 5 and 6, returns to 1 when count reaches 4.
REQ-034 VC1 full, same-cycle write+read on VC1 -> write accepted, count stays 8, head advances.
REQ-035 Interleaved writes to VC0/VC1 with reads on VC1 -> VC0 contents untouched, per-VC order preserved, pointer wrap past index 7 correct.
REQ-036 Reset asserted mid-burst with VC0 at 5 -> all flags return to reset values asynchronously; with VCBUF_ERR_CHECK_EN, read of empty VC0 sets err_o[0]=1.
